// File: rtl/color_sched_pkg.sv
// Shared types for the colour scheduler: colour width, colour type and FSM states.
package color_sched_pkg;

    localparam int COLOR_W = 4;

    typedef logic [COLOR_W-1:0] color_t;

    typedef enum logic {
        IDLE,
        WAIT_FRAME
    } state_e;

endpackage

// File: rtl/color_req_fifo.sv
// Circular request buffer of DEPTH colour ids; a push into a full buffer is
// accepted only when a pop happens in the same cycle.
module color_req_fifo
    import color_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [COLOR_W-1:0]     data_i,
    input  logic                   pop_i,
    output logic [COLOR_W-1:0]     data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    typedef logic [AW:0] cnt_t;
    localparam cnt_t FULL_CNT = cnt_t'(DEPTH);

    color_t        mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    cnt_t          count_q;
    cnt_t          count_d;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/color_sched.sv
// Applies queued keyboard colour requests, or demo-mode steps, at most once per
// frame on the synchronised vsync active edge.
module color_sched
    import color_sched_pkg::*;
#(
    parameter int       DEPTH            = 4,
    parameter int       DEMO_FRAMES      = 60,
    parameter logic [3:0] RESET_COLOR    = 4'd0,
    parameter bit       VSYNC_ACTIVE_LOW = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   vsync,
    input  logic                   key_valid,
    input  logic [COLOR_W-1:0]     key_color,
    input  logic                   demo_toggle,
    output logic [COLOR_W-1:0]     color_id,
    output logic                   demo_active,
    output logic [$clog2(DEPTH):0] pending,
    output logic                   overflow
);

    localparam int   PW      = $clog2(DEPTH) + 1;
    localparam int   FCW     = (DEMO_FRAMES > 1) ? $clog2(DEMO_FRAMES) : 1;
    localparam logic VS_IDLE = logic'(VSYNC_ACTIVE_LOW);

    typedef logic [PW-1:0]  cnt_t;
    typedef logic [FCW-1:0] fcnt_t;
    localparam fcnt_t LAST_FRAME = fcnt_t'(DEMO_FRAMES - 1);

    logic   sync1_q, sync2_q, prev_q;
    logic   tick;
    state_e state_q;
    color_t color_q;
    logic   demo_q;
    logic   ovf_q;
    fcnt_t  fcnt_q;

    color_t fifo_head;
    logic   fifo_full, fifo_empty, fifo_pop, fifo_drop;
    cnt_t   fifo_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= VS_IDLE;
            sync2_q <= VS_IDLE;
            prev_q  <= VS_IDLE;
        end else begin
            sync1_q <= vsync;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign tick      = (sync2_q != VS_IDLE) && (prev_q == VS_IDLE);
    assign fifo_pop  = (state_q == WAIT_FRAME) && tick;
    assign fifo_drop = key_valid && fifo_full && !fifo_pop;

    color_req_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (key_valid),
        .data_i (key_color),
        .pop_i  (fifo_pop),
        .data_o (fifo_head),
        .full_o (fifo_full),
        .empty_o(fifo_empty),
        .count_o(fifo_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            color_q <= RESET_COLOR;
            demo_q  <= 1'b0;
            ovf_q   <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            if (fifo_drop) ovf_q <= 1'b1;

            if (key_valid) begin
                demo_q <= 1'b0;
            end else if (demo_toggle) begin
                demo_q <= ~demo_q;
            end

            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        state_q <= WAIT_FRAME;
                    end else if (tick && demo_q) begin
                        if (fcnt_q == LAST_FRAME) begin
                            fcnt_q  <= '0;
                            color_q <= color_q + 1'b1;
                        end else begin
                            fcnt_q <= fcnt_q + 1'b1;
                        end
                    end
                end
                WAIT_FRAME: begin
                    if (tick) begin
                        color_q <= fifo_head;
                        // A same-cycle push refills the queue, so keep waiting.
                        if (fifo_count == cnt_t'(1) && !key_valid) state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (demo_toggle) fcnt_q <= '0;
        end
    end

    assign color_id    = color_q;
    assign demo_active = demo_q;
    assign overflow    = ovf_q;
    assign pending     = fifo_count;

endmodule
